gray_ramp_converter: RTL

Parametrised successor to the single-channel gray ramp counter used in the column ADC. It runs one shared binary ramp count per conversion and broadcasts it as a registered gray code. It latches a per-channel gray code on each channel's comparator trip, across NCH channels. It adds start/abort/done sequencing, a programmable terminal count, an overflow flag per channel and a registered gray-to-binary readback port.

---
 rtl/gray_adc_pkg.sv | 27 ++
 rtl/gray2bin_decode.sv | 14 +
 rtl/gray_ramp_converter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gray_adc_pkg.sv
// Shared types and gray/binary helpers for the column ADC ramp converters.
package gray_adc_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned MAX_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Helpers work on zero-extended MAX_WIDTH operands, so they serve any WIDTH up to MAX_WIDTH.
   function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
      logic [MAX_WIDTH-1:0] b;
      b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
      for (int i = int'(MAX_WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_decode.sv
// Combinational gray-to-binary decoder, shared with the column readout path.
module gray2bin_decode
   import gray_adc_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
)
(
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin_c
);

   always_comb bin_c = WIDTH'(gray2bin(MAX_WIDTH'(gray)));

endmodule

// File: rtl/gray_ramp_converter.sv
// Multi-channel gray ramp converter: shared ramp count, per-channel trip capture,
// start/abort/done sequencing and a registered binary readback port.
module gray_ramp_converter
   import gray_adc_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned NCH       = 4,
   parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
   localparam int unsigned RSW      = (NCH > 1) ? $clog2(NCH) : 1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [NCH-1:0]   cmp,
   output logic [WIDTH-1:0] gray_out,
   output logic             busy,
   output logic             done,
   output logic [NCH-1:0]   cap_valid,
   output logic [NCH-1:0]   ovf,
   input  logic [RSW-1:0]   rd_sel,
   output logic [WIDTH-1:0] rd_bin
);

   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("gray_ramp_converter: WIDTH out of range 2..16");
   end
   if (NCH < 1 || NCH > 64) begin : g_bad_nch
      $error("gray_ramp_converter: NCH out of range 1..64");
   end
   if (MAX_COUNT < 1 || MAX_COUNT > (1 << WIDTH) - 1) begin : g_bad_max
      $error("gray_ramp_converter: MAX_COUNT out of range");
   end

   localparam logic [WIDTH-1:0] TERM      = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] GRAY_TERM = WIDTH'(bin2gray(MAX_WIDTH'(MAX_COUNT)));

   state_e                      state, state_nxt;
   logic [WIDTH-1:0]            cnt, cnt_nxt;
   logic [NCH-1:0]              cap_valid_nxt, ovf_nxt;
   logic [NCH-1:0][WIDTH-1:0]   code, code_nxt;
   logic [WIDTH-1:0]            sel_code;
   logic [WIDTH-1:0]            rd_bin_c;

   // Next-state, ramp count and capture decisions.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      cap_valid_nxt = cap_valid;
      ovf_nxt       = ovf;
      code_nxt      = code;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt     = RUN;
               cnt_nxt       = '0;
               cap_valid_nxt = '0;
               ovf_nxt       = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt     = IDLE;
               cnt_nxt       = '0;
               cap_valid_nxt = '0;
               ovf_nxt       = '0;
            end else begin
               for (int i = 0; i < int'(NCH); i++) begin
                  if (cmp[i] && !cap_valid[i]) begin
                     code_nxt[i]      = gray_out;
                     cap_valid_nxt[i] = 1'b1;
                  end
               end
               if (cnt == TERM) begin
                  state_nxt = DONE;
                  // Channels that never tripped are pinned to the terminal code.
                  for (int i = 0; i < int'(NCH); i++) begin
                     if (!cap_valid[i] && !cmp[i]) begin
                        code_nxt[i]      = GRAY_TERM;
                        cap_valid_nxt[i] = 1'b1;
                        ovf_nxt[i]       = 1'b1;
                     end
                  end
               end else begin
                  cnt_nxt = cnt + WIDTH'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         gray_out  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cap_valid <= '0;
         ovf       <= '0;
         code      <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         gray_out  <= WIDTH'(bin2gray(MAX_WIDTH'(cnt_nxt)));
         busy      <= (state_nxt == RUN);
         done      <= (state_nxt == DONE);
         cap_valid <= cap_valid_nxt;
         ovf       <= ovf_nxt;
         code      <= code_nxt;
      end
   end

   // Readback mux; selects beyond NCH fall through to zero.
   always_comb begin
      sel_code = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (RSW'(i) == rd_sel) sel_code = code[i];
      end
   end

   gray2bin_decode #(.WIDTH(WIDTH)) u_decode (
      .gray  (sel_code),
      .bin_c (rd_bin_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_bin <= '0;
      else       rd_bin <= rd_bin_c;
   end

endmodule
